multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 160 ++++++++++++++++
 tb/tb_multicycle_control.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS-style datapath; outputs decode from state only.
// Optional ADDI path enabled by defining MULTICYCLE_CONTROL_ADDI_EN.
module multicycle_control #(
   parameter int unsigned OPCODE_WIDTH = 6
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [OPCODE_WIDTH-1:0] opcode,
   output logic                    PCWrite,
   output logic                    PCWriteCond,
   output logic                    IorD,
   output logic                    MemRead,
   output logic                    MemWrite,
   output logic                    MemtoReg,
   output logic                    IRWrite,
   output logic                    ALUSrcA,
   output logic                    RegWrite,
   output logic                    RegDst,
   output logic [1:0]              PCSource,
   output logic [1:0]              ALUSrcB,
   output logic [1:0]              ALUOp,
   output logic [3:0]              state
);

   typedef enum logic [3:0] {
      StFetch   = 4'd0,
      StDecode  = 4'd1,
      StMemAddr = 4'd2,
      StMemRd   = 4'd3,
      StMemWb   = 4'd4,
      StMemWr   = 4'd5,
      StExec    = 4'd6,
      StAluWb   = 4'd7,
      StBranch  = 4'd8,
      StJump    = 4'd9,
      StAddiEx  = 4'd10,
      StAddiWb  = 4'd11
   } state_e;

   localparam logic [OPCODE_WIDTH-1:0] OpLw   = OPCODE_WIDTH'(6'b100011);
   localparam logic [OPCODE_WIDTH-1:0] OpSw   = OPCODE_WIDTH'(6'b101011);
   localparam logic [OPCODE_WIDTH-1:0] OpR    = OPCODE_WIDTH'(6'b000000);
   localparam logic [OPCODE_WIDTH-1:0] OpBeq  = OPCODE_WIDTH'(6'b000100);
   localparam logic [OPCODE_WIDTH-1:0] OpJ    = OPCODE_WIDTH'(6'b000010);
`ifdef MULTICYCLE_CONTROL_ADDI_EN
   localparam logic [OPCODE_WIDTH-1:0] OpAddi = OPCODE_WIDTH'(6'b001000);
`endif

   state_e state_q, state_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StFetch;
      end else begin
         state_q <= state_d;
      end
   end

   // Opcode is only looked at in DECODE and MEMADDR; unknown opcodes and states fall back to FETCH.
   always_comb begin
      state_d = StFetch;
      case (state_q)
         StFetch:   state_d = StDecode;
         StDecode: begin
            if (opcode == OpLw || opcode == OpSw) state_d = StMemAddr;
            else if (opcode == OpR)               state_d = StExec;
            else if (opcode == OpBeq)             state_d = StBranch;
            else if (opcode == OpJ)               state_d = StJump;
`ifdef MULTICYCLE_CONTROL_ADDI_EN
            else if (opcode == OpAddi)            state_d = StAddiEx;
`endif
            else                                  state_d = StFetch;
         end
         StMemAddr: begin
            if (opcode == OpLw)      state_d = StMemRd;
            else if (opcode == OpSw) state_d = StMemWr;
            else                     state_d = StFetch;
         end
         StMemRd:   state_d = StMemWb;
         StExec:    state_d = StAluWb;
`ifdef MULTICYCLE_CONTROL_ADDI_EN
         StAddiEx:  state_d = StAddiWb;
`endif
         default:   state_d = StFetch;
      endcase
   end

   // Reset gates every output so no write can fire while reset is held.
   always_comb begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      MemtoReg    = 1'b0;
      IRWrite     = 1'b0;
      ALUSrcA     = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      PCSource    = 2'b00;
      ALUSrcB     = 2'b00;
      ALUOp       = 2'b00;
      if (!reset) begin
         case (state_q)
            StFetch: begin
               MemRead = 1'b1;
               IRWrite = 1'b1;
               ALUSrcB = 2'b01;
               PCWrite = 1'b1;
            end
            StDecode:  ALUSrcB = 2'b11;
            StMemAddr: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'b10;
            end
            StMemRd: begin
               MemRead = 1'b1;
               IorD    = 1'b1;
            end
            StMemWb: begin
               RegWrite = 1'b1;
               MemtoReg = 1'b1;
            end
            StMemWr: begin
               MemWrite = 1'b1;
               IorD     = 1'b1;
            end
            StExec: begin
               ALUSrcA = 1'b1;
               ALUOp   = 2'b10;
            end
            StAluWb: begin
               RegWrite = 1'b1;
               RegDst   = 1'b1;
            end
            StBranch: begin
               ALUSrcA     = 1'b1;
               ALUOp       = 2'b01;
               PCWriteCond = 1'b1;
               PCSource    = 2'b01;
            end
            StJump: begin
               PCWrite  = 1'b1;
               PCSource = 2'b10;
            end
`ifdef MULTICYCLE_CONTROL_ADDI_EN
            StAddiEx: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'b10;
            end
            StAddiWb:  RegWrite = 1'b1;
`endif
            default: ;
         endcase
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: expected state/output sequences are queued
// per instruction and popped each cycle for comparison.
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] opcode = 6'b0;
   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
   logic       ALUSrcA, RegWrite, RegDst;
   logic [1:0] PCSource, ALUSrcB, ALUOp;
   logic [3:0] state;

   int checks = 0;
   int failures = 0;
   int exp_q[$];

   multicycle_control #(.OPCODE_WIDTH(6)) dut (
      .clk(clk), .reset(reset), .opcode(opcode),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
      .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA),
      .RegWrite(RegWrite), .RegDst(RegDst), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
      .ALUOp(ALUOp), .state(state)
   );

   always #5 clk = ~clk;

   // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,ALUSrcA,RegWrite,RegDst,
   //  PCSource,ALUSrcB,ALUOp}
   wire logic [15:0] outs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                             ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp};

   function automatic logic [15:0] exp_out(input int s);
      logic pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd;
      logic [1:0] pcs, asb, aop;
      {pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd} = 10'b0;
      pcs = 2'b00; asb = 2'b00; aop = 2'b00;
      case (s)
         0:  begin mrd = 1; irw = 1; asb = 2'b01; pcw = 1; end
         1:  asb = 2'b11;
         2:  begin asa = 1; asb = 2'b10; end
         3:  begin mrd = 1; iord = 1; end
         4:  begin rw = 1; m2r = 1; end
         5:  begin mwr = 1; iord = 1; end
         6:  begin asa = 1; aop = 2'b10; end
         7:  begin rw = 1; rd = 1; end
         8:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
         9:  begin pcw = 1; pcs = 2'b10; end
`ifdef MULTICYCLE_CONTROL_ADDI_EN
         10: begin asa = 1; asb = 2'b10; end
         11: rw = 1;
`endif
         default: ;
      endcase
      return {pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd, pcs, asb, aop};
   endfunction

   task automatic check_state(input string tag, input int es, input logic [15:0] eo);
      checks++;
      assert (state === 4'(es)) else begin
         failures++;
         $error("FAIL %s state got=%0d exp=%0d", tag, state, es);
      end
      checks++;
      assert (outs === eo) else begin
         failures++;
         $error("FAIL %s outputs(state %0d) got=%b exp=%b", tag, es, outs, eo);
      end
   endtask

   // Hold reset two cycles, check outputs are forced low, release with the given opcode.
   task automatic do_reset(input logic [5:0] op);
      @(negedge clk);
      reset = 1'b1;
      #1 check_state("in_reset", 0, 16'h0000);
      repeat (2) @(negedge clk);
      opcode = op;
      reset = 1'b0;
      #1;
   endtask

   // Pop and compare one expected state per cycle until the scoreboard drains.
   task automatic drain(input string tag);
      int es;
      while (exp_q.size() > 0) begin
         es = exp_q.pop_front();
         check_state(tag, es, exp_out(es));
         if (exp_q.size() > 0) begin
            @(negedge clk);
            #1;
         end
      end
   endtask

   initial begin
      // LW
      do_reset(6'b100011);
      exp_q = {0, 1, 2, 3, 4, 0};
      drain("lw");

      // SW
      do_reset(6'b101011);
      exp_q = {0, 1, 2, 5, 0};
      drain("sw");

      // R-type
      do_reset(6'b000000);
      exp_q = {0, 1, 6, 7, 0};
      drain("rtype");

      // BEQ
      do_reset(6'b000100);
      exp_q = {0, 1, 8, 0};
      drain("beq");

      // J
      do_reset(6'b000010);
      exp_q = {0, 1, 9, 0};
      drain("jump");

      // Unrecognised opcode
      do_reset(6'b111111);
      exp_q = {0, 1, 0};
      drain("illegal");

      // ADDI
      do_reset(6'b001000);
`ifdef MULTICYCLE_CONTROL_ADDI_EN
      exp_q = {0, 1, 10, 11, 0};
`else
      exp_q = {0, 1, 0};
`endif
      drain("addi");

      // Opcode change after MEMADDR must not alter the LW path
      do_reset(6'b100011);
      exp_q = {0, 1, 2, 3};
      drain("lw_pre");
      opcode = 6'b000010;
      exp_q = {3, 4, 0};
      drain("lw_opchg");

      // Asynchronous reset mid-cycle in MEMRD
      do_reset(6'b100011);
      exp_q = {0, 1, 2, 3};
      drain("mid_pre");
      #2 reset = 1'b1;
      #1 check_state("async_reset", 0, 16'h0000);
      @(negedge clk);
      check_state("async_hold", 0, 16'h0000);
      reset = 1'b0;
      #1;
      exp_q = {0, 1, 2, 3, 4, 0};
      drain("after_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
